// File: rtl/cpu_harness_pkg.sv
// Shared types and constants for the CPU test harness controller.
package cpu_harness_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CPU_RST,
    RUN,
    DONE
  } harness_state_e;

  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h0000_0100;
  localparam int unsigned PASS_CODE           = 1;

endpackage

// File: rtl/harness_cycle_counter.sv
// Up-counter with clear, load, enable and a terminal-count flag.
module harness_cycle_counter
  import cpu_harness_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == term_val);

endmodule

// File: rtl/cpu_test_harness_ctrl.sv
// Program-load / CPU-reset / run controller with tohost and timeout end detection.
// Optional CPU_HARNESS_PC_WATCH_EN adds pc/end_pc ports that end the run on a PC match.
module cpu_test_harness_ctrl
  import cpu_harness_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              IMEM_DEPTH     = 64,
  parameter int              RST_CYCLES     = 4,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(DEFAULT_TOHOST_ADDR),
  parameter int              TIMEOUT_CYCLES = 1000,
  localparam int             AW             = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            prog_valid,
  output logic            prog_ready,
  input  logic [XLEN-1:0] prog_data,
  input  logic            prog_last,
  output logic            imem_we,
  output logic [AW-1:0]   imem_waddr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            cpu_reset,
  input  logic            dmem_we,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [31:0]     cycle_count
`ifdef CPU_HARNESS_PC_WATCH_EN
  ,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] end_pc
`endif
);

  harness_state_e state_q, state_d;
  logic [AW-1:0]  wcnt_q, wcnt_d;
  logic           cpu_reset_q, cpu_reset_d;
  logic           done_q, done_d;
  logic           pass_q, pass_d;
  logic           timeout_q, timeout_d;

  logic           accept, last_word, start_ok;
  logic           rst_tc, run_tc, tohost_hit, pc_hit;
  logic [31:0]    rst_count_unused;

  assign start_ok   = start && (state_q == IDLE || state_q == DONE);
  assign prog_ready = (state_q == LOAD);
  assign accept     = prog_ready && prog_valid;
  assign last_word  = prog_last || (wcnt_q == AW'(IMEM_DEPTH - 1));
  assign tohost_hit = dmem_we && (dmem_addr == TOHOST_ADDR);

`ifdef CPU_HARNESS_PC_WATCH_EN
  assign pc_hit = (pc == end_pc);
`else
  assign pc_hit = 1'b0;
`endif

  // Cleared throughout LOAD so the reset hold always starts from zero.
  harness_cycle_counter #(.W(32)) u_rst_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (state_q == LOAD),
    .load     (1'b0),
    .load_val (32'd0),
    .en       (state_q == CPU_RST),
    .term_val (32'(RST_CYCLES - 1)),
    .count    (rst_count_unused),
    .tc       (rst_tc)
  );

  harness_cycle_counter #(.W(32)) u_run_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (start_ok),
    .load     (1'b0),
    .load_val (32'd0),
    .en       (state_q == RUN),
    .term_val (32'(TIMEOUT_CYCLES - 1)),
    .count    (cycle_count),
    .tc       (run_tc)
  );

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = LOAD;
          wcnt_d      = '0;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          if (last_word) begin
            state_d = CPU_RST;
          end
          // Saturate at the top word; the load ends there anyway.
          if (wcnt_q != AW'(IMEM_DEPTH - 1)) begin
            wcnt_d = wcnt_q + AW'(1);
          end
        end
      end
      CPU_RST: begin
        if (rst_tc) begin
          state_d     = RUN;
          cpu_reset_d = 1'b0;
        end
      end
      RUN: begin
        if (tohost_hit || pc_hit || run_tc) begin
          state_d     = DONE;
          done_d      = 1'b1;
          cpu_reset_d = 1'b1;
          pass_d      = tohost_hit ? (dmem_wdata == XLEN'(PASS_CODE)) : pc_hit;
          timeout_d   = !tohost_hit && !pc_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  assign imem_we    = accept;
  assign imem_waddr = wcnt_q;
  assign imem_wdata = prog_data;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign timeout    = timeout_q;

endmodule

// File: doc/cpu_test_harness_ctrl.md
Name: cpu_test_harness_ctrl

Overview:
- Synthesizable program-load and run controller that automates the test flow: stream a program into instruction memory, hold the CPU in reset, release it, then detect end of test.
- Sits between a host or bench stimulus stream and the `top` CPU: drives the imem write port and the CPU reset, and snoops the dmem write bus.
- Generalised in memory depth, data width, reset length, tohost address and timeout.
- Reports pass, fail or timeout, plus the number of run cycles.

Parameters:
- XLEN, 32, data and address width of the program stream and the dmem snoop bus.
- IMEM_DEPTH, 64, instruction memory depth in words; power of two, at least 2.
- RST_CYCLES, 4, number of cycles the CPU is held in reset after loading; at least 1.
- TOHOST_ADDR, 32'h0000_0100, byte address whose write ends the test.
- TIMEOUT_CYCLES, 1000, run-cycle limit; at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- prog_valid  in  1  program word valid.
- prog_ready  out  1  controller accepts a word.
- prog_data  in  XLEN  instruction word.
- prog_last  in  1  marks the final word of the program.
- imem_we  out  1  imem write enable.
- imem_waddr  out  $clog2(IMEM_DEPTH)  imem word address.
- imem_wdata  out  XLEN  imem write data.
- cpu_reset  out  1  active-high reset to the CPU.
- dmem_we  in  1  snooped CPU store enable.
- dmem_addr  in  XLEN  snooped store byte address.
- dmem_wdata  in  XLEN  snooped store data.
- done  out  1  test finished.
- pass  out  1  tohost was written with value 1.
- timeout  out  1  run-cycle limit was reached.
- cycle_count  out  32  number of RUN cycles.

Behaviour:
- States: IDLE, LOAD, CPU_RST, RUN, DONE.
- Reset (reset=0, asynchronous):
  - state=IDLE, cpu_reset=1, prog_ready=0, imem_we=0, imem_waddr=0, done=0, pass=0, timeout=0, cycle_count=0.
- IDLE:
  - cpu_reset=1.
  - start -> LOAD; the word counter is cleared.
- LOAD:
  - prog_ready=1.
  - A word is accepted when prog_valid and prog_ready are both high.
  - On acceptance, in the same cycle (combinational): imem_we=1, imem_waddr=counter, imem_wdata=prog_data.
  - The counter increments after each accepted word.
  - Accepting a word with prog_last=1, or accepting the word at counter==IMEM_DEPTH-1, moves to CPU_RST. In that case prog_ready is 0 from the next cycle; there is no wrap.
  - prog_valid=0 stalls the load indefinitely.
- CPU_RST:
  - cpu_reset=1 for exactly RST_CYCLES cycles, then -> RUN.
  - cpu_reset is registered and is 0 from the first RUN cycle.
- RUN:
  - cycle_count increments every cycle.
  - A store with dmem_we=1 and dmem_addr==TOHOST_ADDR -> DONE; pass is registered as (dmem_wdata==1).
  - cycle_count reaching TIMEOUT_CYCLES -> DONE with timeout=1 and pass=0.
  - If a tohost store and the timeout occur in the same cycle, tohost wins and timeout=0.
  - Stores to any other address are ignored.
- DONE:
  - done=1; cpu_reset=1 from the first DONE cycle.
  - pass, timeout and cycle_count are frozen.
  - start clears done, pass, timeout and cycle_count, then -> LOAD.
- start in LOAD, CPU_RST or RUN is ignored.
- Reset asserted mid-load or mid-run aborts immediately to the reset values. The imem contents are not cleared.

Optional Feature:
- Macro: CPU_HARNESS_PC_WATCH_EN.
- When defined, two ports are added:
  - pc (in, XLEN): the CPU's current PC.
  - end_pc (in, XLEN): PC value that ends the test.
- In RUN, pc==end_pc -> DONE with pass=1.
- Priority within a cycle: tohost, then pc match, then timeout.
- When undefined, the ports are absent and only tohost or timeout ends the run.

Decomposition:
- Package cpu_harness_pkg holds:
  - the harness_state_e enum (IDLE, LOAD, CPU_RST, RUN, DONE);
  - the default TOHOST_ADDR;
  - the PASS_CODE=1 constant.
- One sub-module, harness_cycle_counter: a loadable/clearable counter with enable and terminal-count flag. It is instantiated twice:
  - for the CPU_RST reset length;
  - for the RUN timeout and cycle_count.

Test Plan:
- Reset then start; stream 16 words with prog_last on the 16th; CPU stores 1 to 0x100 at run cycle 40 -> imem_waddr runs 0..15; cpu_reset low for the run; done=1, pass=1, cycle_count=40.
- Tohost store of value 3 -> done=1, pass=0, timeout=0.
- No tohost store, TIMEOUT_CYCLES=50 -> done=1 at cycle_count=50, timeout=1, pass=0, cpu_reset back to 1.
- IMEM_DEPTH=8, 10 words offered without prog_last -> exactly 8 writes at addresses 0..7; prog_ready=0 afterwards; enters CPU_RST.
- prog_valid toggling every other cycle, plus start pulsed during RUN -> no lost or duplicated words; the start is ignored.
- reset driven low mid-RUN, then restart -> all outputs return to their reset values asynchronously; the second full run passes.
